shift_serializer_ctrl: RTL and testbench
========================================

Name: shift_serializer_ctrl

Overview:
Parallel-in, serial-out transmit stage that sits directly downstream of the 4-bit universal shift register's parallel output. It accepts one WIDTH-bit word through a valid/ready handshake and shifts it out one bit per accepted cycle. Bit order (LSB-first or MSB-first) is selectable per word. It applies back-pressure upstream and accepts back-pressure from the serial sink.

Parameters:
WIDTH, 4, word width in bits; legal range is 2 to 32.
CW, $clog2(WIDTH), width of the bit counter.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
Clear  input  1  synchronous, active-high reset.
I_par  input  WIDTH  parallel word to transmit.
load_valid  input  1  I_par and dir are valid this cycle.
load_ready  output  1  block can accept a word this cycle.
dir  input  1  sampled with the word: 0 = LSB-first (right shift), 1 = MSB-first (left shift).
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_ready  input  1  sink accepts ser_out this cycle.
busy  output  1  a word is in flight.
done  output  1  one-cycle pulse after the last bit of a word is accepted.

Behaviour:
- Clear sampled high at a rising edge:
  - state = IDLE; shift register = 0; counter = 0; dir latch = 0; done = 0.
  - Effective after that edge: ser_valid = 0, busy = 0, load_ready = 1.
  - Clear takes priority over every other input, including mid-word. A word in flight is discarded with no done pulse.
- States:
  - IDLE: ser_valid = 0, busy = 0.
  - SHIFT: ser_valid = 1, busy = 1.
- Load handshake:
  - Load condition is load_valid && load_ready at a rising edge.
  - On load: shift register <= I_par, dir latch <= dir, counter <= WIDTH-1, state <= SHIFT.
  - The first bit is presented in the cycle after the load edge, so load-to-first-bit latency is 1 cycle.
- ser_out:
  - LSB-first: ser_out = sr[0].
  - MSB-first: ser_out = sr[WIDTH-1].
  - ser_out is driven 0 whenever ser_valid = 0.
- Bit transfer:
  - A transfer is ser_valid && ser_ready at a rising edge.
  - On a transfer with counter != 0:
    - LSB-first: sr <= {1'b0, sr[WIDTH-1:1]}.
    - MSB-first: sr <= {sr[WIDTH-2:0], 1'b0}.
    - counter decrements by 1.
  - If ser_ready = 0: sr, counter and ser_out hold (stall of any length). done stays 0.
- Last bit (counter == 0 and a transfer occurs):
  - done = 1 in the following cycle only.
  - If load_valid is also high in that same cycle, the new word loads, state stays SHIFT, and there are no bubbles between words.
  - Otherwise state <= IDLE and sr <= 0.
- load_ready = (state == IDLE) || (state == SHIFT && counter == 0 && ser_ready).
  - This is combinational from ser_ready. There is no combinational path from load_valid to any output.
- I_par and dir are ignored while load_ready = 0. A changing dir mid-word has no effect.
- A word always produces exactly WIDTH transfers. Total cycles per word = WIDTH + number of stall cycles.
- done and Clear in the same cycle: Clear wins and done = 0 next cycle.

Test Plan:
1. Reset mid-word: load 4'b1011 LSB-first with ser_ready = 1, assert Clear on the 2nd bit cycle -> the next cycle shows ser_valid = 0, busy = 0, load_ready = 1, ser_out = 0, and done never pulses.
2. LSB-first, no stall: load 4'b1011, dir = 0, ser_ready = 1 -> ser_out is 1,1,0,1 on cycles 1–4 after the load edge; done = 1 on cycle 5; ser_valid = 0 on cycle 5.
3. MSB-first: load 4'b1011, dir = 1 -> ser_out is 1,0,1,1; done on cycle 5.
4. Back-pressure: load 4'b0110 LSB-first, hold ser_ready = 0 for 3 cycles after bit 2 is presented -> ser_out holds at 1 for the stall, the sequence is 0,1,1,0, and done arrives 3 cycles later (cycle 8).
5. Back-to-back: load 4'b1100 (dir = 0) then 4'b0011 (dir = 1), with load_valid held high -> the second load is accepted on the last-bit cycle of the first word; ser_valid stays 1 for 8 consecutive cycles with ser_out 0,0,1,1,0,0,1,1; done pulses on cycles 5 and 9.
6. Busy ignore: while shifting 4'b1001, drive load_valid = 1 with I_par = 4'b1111 on bit cycle 2 -> load_ready = 0, the output is unaffected (1,0,0,1), and 4'b1111 is accepted only on the last-bit cycle.

Source files
------------

// File: rtl/shift_serializer_ctrl.sv
// Parallel-in, serial-out transmit stage with valid/ready on both sides.
// Bit order is latched per word; back-to-back words load on the last-bit cycle.
module shift_serializer_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [WIDTH-1:0] I_par,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             dir,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  // state    | meaning
  // ST_IDLE  | no word held, ready for a load
  // ST_SHIFT | word in flight, ser_out valid, r_cnt = bits left after this one
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LP_CNT_LOAD = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_done, w_done_nxt;
  logic             w_xfer;
  logic             w_load;
  logic             w_last;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;

    ser_valid  = (r_state == ST_SHIFT);
    busy       = (r_state == ST_SHIFT);
    done       = r_done;
    w_last     = (r_cnt == '0);
    // Ready on the last-bit cycle lets the next word follow with no bubble.
    load_ready = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_last && ser_ready);
    w_xfer     = ser_valid && ser_ready;
    w_load     = load_valid && load_ready;
    ser_out    = ser_valid ? (r_dir ? r_sr[WIDTH-1] : r_sr[0]) : 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_sr_nxt    = I_par;
          w_dir_nxt   = dir;
          w_cnt_nxt   = LP_CNT_LOAD;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_xfer) begin
          w_done_nxt = w_last;
          if (!w_last) begin
            w_sr_nxt  = r_dir ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (w_load) begin
            w_sr_nxt    = I_par;
            w_dir_nxt   = dir;
            w_cnt_nxt   = LP_CNT_LOAD;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_sr_nxt    = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed bit sequences, a negedge
// monitor pops one per accepted bit and tracks the expected done pulse.
module tb_shift_serializer_ctrl;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         Clear;
  logic [W-1:0] I_par;
  logic         load_valid;
  logic         load_ready;
  logic         dir;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         busy;
  logic         done;

  shift_serializer_ctrl #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .I_par      (I_par),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dir        (dir),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_done_next = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b, input logic last);
    exp_t e;
    e.b    = b;
    e.last = last;
    q.push_back(e);
  endtask

  // s[3] is the first bit expected on ser_out
  task automatic push_seq(input logic [3:0] s);
    for (int i = 3; i >= 0; i--) push_bit(s[i], (i == 0));
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (Clear) begin
      exp_done_next = 1'b0;
    end else begin
      chk("done", done, exp_done_next);
      exp_done_next = 1'b0;
      if (!ser_valid) chk("idle_ser_out", ser_out, 1'b0);
      if (ser_valid && ser_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("ser_out", ser_out, e.b);
          if (e.last) exp_done_next = 1'b1;
        end
      end
    end
  end

  initial begin
    Clear = 1'b1; I_par = '0; load_valid = 1'b0; dir = 1'b0; ser_ready = 1'b0;
    step; step;
    Clear = 1'b0;
    #1;
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_done", done, 1'b0);

    // Test 1: Clear mid-word, only the first bit is ever accepted
    ser_ready = 1'b1; load_valid = 1'b1; I_par = 4'b1011; dir = 1'b0;
    push_bit(1'b1, 1'b0);
    step; load_valid = 1'b0;
    step; Clear = 1'b1;
    step; Clear = 1'b0;
    #1;
    chk("t1_ser_valid", ser_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_load_ready", load_ready, 1'b1);
    chk("t1_ser_out", ser_out, 1'b0);
    step; step;

    // Test 2: LSB-first 1011 -> 1,1,0,1; dir toggled mid-word
    load_valid = 1'b1; I_par = 4'b1011; dir = 1'b0;
    push_seq(4'b1101);
    step; load_valid = 1'b0; I_par = '0;
    #1;
    chk("t2_ser_valid_c1", ser_valid, 1'b1);
    chk("t2_busy_c1", busy, 1'b1);
    step; dir = 1'b1;
    step; step;
    step; dir = 1'b0;
    #1;
    chk("t2_ser_valid_c5", ser_valid, 1'b0);
    chk("t2_done_c5", done, 1'b1);
    chk("t2_busy_c5", busy, 1'b0);

    // Test 3: MSB-first 1011 -> 1,0,1,1
    load_valid = 1'b1; I_par = 4'b1011; dir = 1'b1;
    push_seq(4'b1011);
    step; load_valid = 1'b0; dir = 1'b0;
    repeat (4) step;
    #1;
    chk("t3_done_c5", done, 1'b1);
    chk("t3_ser_valid_c5", ser_valid, 1'b0);

    // Test 4: 0110 LSB-first with a 3-cycle stall on bit 2
    load_valid = 1'b1; I_par = 4'b0110; dir = 1'b0;
    push_seq(4'b0110);
    step; load_valid = 1'b0;
    step; ser_ready = 1'b0;
    #1;
    chk("t4_stall_out_c2", ser_out, 1'b1);
    chk("t4_stall_lr_c2", load_ready, 1'b0);
    step; #1;
    chk("t4_stall_out_c3", ser_out, 1'b1);
    step; #1;
    chk("t4_stall_out_c4", ser_out, 1'b1);
    chk("t4_stall_busy_c4", busy, 1'b1);
    step; ser_ready = 1'b1;
    step; step;
    step; #1;
    chk("t4_done_c8", done, 1'b1);

    // Test 5: back-to-back 1100 LSB then 0011 MSB, load_valid held
    load_valid = 1'b1; I_par = 4'b1100; dir = 1'b0;
    push_seq(4'b0011);
    push_seq(4'b0011);
    step; I_par = 4'b0011; dir = 1'b1;
    #1;
    chk("t5_ser_valid_c1", ser_valid, 1'b1);
    for (int c = 2; c <= 8; c++) begin
      step;
      if (c == 5) load_valid = 1'b0;
      #1;
      chk("t5_ser_valid", ser_valid, 1'b1);
      if (c == 2) chk("t5_load_ready_c2", load_ready, 1'b0);
      if (c == 4) chk("t5_load_ready_c4", load_ready, 1'b1);
    end
    step; #1;
    chk("t5_ser_valid_c9", ser_valid, 1'b0);
    chk("t5_done_c9", done, 1'b1);
    dir = 1'b0;

    // Test 6: load attempt while busy is held off until the last-bit cycle
    load_valid = 1'b1; I_par = 4'b1001; dir = 1'b0;
    push_seq(4'b1001);
    push_seq(4'b1111);
    step; load_valid = 1'b0;
    step; load_valid = 1'b1; I_par = 4'b1111; dir = 1'b1;
    #1;
    chk("t6_load_ready_c2", load_ready, 1'b0);
    step; #1;
    chk("t6_load_ready_c3", load_ready, 1'b0);
    step; #1;
    chk("t6_load_ready_c4", load_ready, 1'b1);
    step; load_valid = 1'b0;
    repeat (3) step;
    step; #1;
    chk("t6_done_c9", done, 1'b1);
    chk("t6_ser_valid_c9", ser_valid, 1'b0);

    step; step;
    chk("queue_drained", (q.size() == 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
